// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Serial transmitter that shifts a DATA_W-bit word out LSB-first on one line:
//   start bit (0), DATA_W data bits, optional even-parity bit, stop bit (1).
//   Each bit lasts CLKS_PER_BIT clocks. o_done pulses for one cycle when the
//   stop bit completes; it drives the upstream count generator's enable.
//
// Build option:
//   SERIAL_TX_PARITY_EN - when defined, an even parity bit (XOR of the word)
//   is sent between the last data bit and the stop bit.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_valid  upstream word available
//   i_data   word to transmit, sampled only on acceptance
//   o_ready  high only in IDLE; the block can accept a word
//   o_tx     serial line, idles high
//   o_busy   a frame is in progress (any state except IDLE)
//   o_done   one-cycle pulse on the edge that returns STOP -> IDLE
//   o_state  current FSM state, for observation only
//
// Handshake: a word is accepted on any rising edge where i_valid and o_ready
// are both 1; i_data is latched on that same edge and o_ready drops with it.
// i_valid and i_data are ignored while o_ready is 0.
//
// All outputs are registered. They are computed from the next-state values,
// so o_tx goes low on the acceptance edge and o_done rises on the edge that
// enters IDLE.

module serial_word_tx #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Bit clock runs in every non-idle state and wraps at each bit boundary.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          state_d = S_START;
          shift_d = i_data;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          // Even parity captured from the word as accepted, so later
          // i_data changes cannot disturb it.
          par_d   = ^i_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the cycle that follows the edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx with DATA_W=10, CLKS_PER_BIT=4.
// Frame expectations follow the parity build option of the compiled RTL.

module tb_serial_word_tx;

  localparam int W   = 10;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (W + 2 + PAR) * CPB;   // 48 without parity, 52 with
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] data = '0;
  logic         ready, tx, busy, done;
  logic [2:0]   state;

  int checks = 0;
  int passed = 0;

  // Per-cycle capture of the DUT outputs; cycle 0 is the cycle right after
  // the acceptance edge.
  logic cap_tx   [0:255];
  logic cap_rdy  [0:255];
  logic cap_busy [0:255];
  int   cap_done_n;
  int   cap_done_at [0:3];

  serial_word_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done),
    .o_state (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- expected-value model ----------------
  // Line value in cycle c of a frame carrying word d.
  function automatic logic exp_bit(input logic [W-1:0] d, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
    if (PAR == 1 && k == W + 1) return ^d;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a sample point with the DUT idle; returns at the sample point
  // of cycle 0 of the new frame.
  task automatic send(input logic [W-1:0] d, input bit hold);
    valid = 1'b1;
    data  = d;
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic capture(input int n, input int chg_at, input logic [W-1:0] chg_data,
                         input int von_at, input int voff_at);
    cap_done_n = 0;
    for (int i = 0; i < 4; i++) cap_done_at[i] = -1;
    for (int c = 0; c < n; c++) begin
      cap_tx[c]   = tx;
      cap_rdy[c]  = ready;
      cap_busy[c] = busy;
      if (done === 1'b1) begin
        if (cap_done_n < 4) cap_done_at[cap_done_n] = c;
        cap_done_n++;
      end
      if (c == chg_at)  data  = chg_data;
      if (c == von_at)  valid = 1'b1;
      if (c == voff_at) valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b expected 1", tx); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
    checks++; if (state !== ST_IDLE) $display("FAIL rst_state: got %0d expected %0d", state, ST_IDLE); else passed++;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); else passed++;
    // Reset and valid on the same edge: reset wins.
    rst = 1'b1; valid = 1'b1; data = 10'h3FF;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_vs_valid_busy: got %b expected 0", busy); else passed++;
    checks++; if (state !== ST_IDLE) $display("FAIL rst_vs_valid_state: got %0d expected %0d", state, ST_IDLE); else passed++;
    rst = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) $display("FAIL rst_vs_valid_tx: got %b expected 1", tx); else passed++;
  endtask

  task automatic test_single_frame();
    send(10'h2A5, 1'b0);
    capture(FRAME + 4, -1, '0, -1, -1);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(10'h2A5, c))
        $display("FAIL single_tx[%0d]: got %b expected %b", c, cap_tx[c], exp_bit(10'h2A5, c));
      else passed++;
    end
    checks++; if (cap_rdy[0] !== 1'b0) $display("FAIL single_ready0: got %b expected 0", cap_rdy[0]); else passed++;
    checks++; if (cap_busy[0] !== 1'b1) $display("FAIL single_busy0: got %b expected 1", cap_busy[0]); else passed++;
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL single_done_at: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
    checks++; if (cap_done_n != 1) $display("FAIL single_done_n: got %0d expected 1", cap_done_n); else passed++;
    checks++; if (cap_tx[FRAME] !== 1'b1) $display("FAIL single_tx_done: got %b expected 1", cap_tx[FRAME]); else passed++;
    checks++; if (cap_rdy[FRAME] !== 1'b1) $display("FAIL single_ready_done: got %b expected 1", cap_rdy[FRAME]); else passed++;
    checks++; if (cap_busy[FRAME] !== 1'b0) $display("FAIL single_busy_done: got %b expected 0", cap_busy[FRAME]); else passed++;
  endtask

  task automatic test_parity();
    logic exp_a, exp_b;
    // 10'h2A5 has five ones -> parity 1; 10'h003 has two -> parity 0.
    // Without parity that window is the stop bit (1).
    exp_a = 1'b1;
    exp_b = (PAR == 1) ? 1'b0 : 1'b1;
    send(10'h2A5, 1'b0);
    capture(FRAME + 2, -1, '0, -1, -1);
    for (int c = (W + 1) * CPB; c < (W + 2) * CPB; c++) begin
      checks++;
      if (cap_tx[c] !== exp_a) $display("FAIL par_2a5[%0d]: got %b expected %b", c, cap_tx[c], exp_a); else passed++;
    end
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL par_2a5_done_at: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
    send(10'h003, 1'b0);
    capture(FRAME + 2, -1, '0, -1, -1);
    for (int c = (W + 1) * CPB; c < (W + 2) * CPB; c++) begin
      checks++;
      if (cap_tx[c] !== exp_b) $display("FAIL par_003[%0d]: got %b expected %b", c, cap_tx[c], exp_b); else passed++;
    end
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL par_003_done_at: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
  endtask

  task automatic test_back_to_back();
    send(10'h001, 1'b1);
    // Present the second word right away; valid stays high until it is taken.
    capture(2 * FRAME + 6, 0, 10'h3FF, -1, FRAME + 1);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(10'h001, c))
        $display("FAIL b2b_first[%0d]: got %b expected %b", c, cap_tx[c], exp_bit(10'h001, c));
      else passed++;
    end
    checks++; if (cap_tx[FRAME] !== 1'b1) $display("FAIL b2b_gap: got %b expected 1", cap_tx[FRAME]); else passed++;
    for (int c = FRAME + 1; c <= 2 * FRAME; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(10'h3FF, c - FRAME - 1))
        $display("FAIL b2b_second[%0d]: got %b expected %b", c, cap_tx[c], exp_bit(10'h3FF, c - FRAME - 1));
      else passed++;
    end
    checks++; if (cap_done_n != 2) $display("FAIL b2b_done_n: got %0d expected 2", cap_done_n); else passed++;
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL b2b_done0: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
    checks++; if (cap_done_at[1] != 2 * FRAME + 1) $display("FAIL b2b_done1: got %0d expected %0d", cap_done_at[1], 2 * FRAME + 1); else passed++;
  endtask

  task automatic test_busy_protect();
    int rdy_high;
    send(10'h155, 1'b0);
    capture(FRAME + 8, 8, 10'h2AA, 8, 9);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(10'h155, c))
        $display("FAIL busy_tx[%0d]: got %b expected %b", c, cap_tx[c], exp_bit(10'h155, c));
      else passed++;
    end
    rdy_high = 0;
    for (int c = 0; c < FRAME; c++) if (cap_rdy[c] !== 1'b0) rdy_high++;
    checks++; if (rdy_high != 0) $display("FAIL busy_ready: got %0d ready cycles expected 0", rdy_high); else passed++;
    checks++; if (cap_done_n != 1) $display("FAIL busy_done_n: got %0d expected 1", cap_done_n); else passed++;
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL busy_done_at: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
    checks++; if (cap_busy[FRAME + 7] !== 1'b0) $display("FAIL busy_after: got %b expected 0", cap_busy[FRAME + 7]); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int low_cycles;
    send(10'h0F0, 1'b0);
    // Stop at cycle 26, inside data bit 5 (cycles 24..27).
    capture(26, -1, '0, -1, -1);
    checks++; if (cap_tx[25] !== 1'b1) $display("FAIL mid_bit5: got %b expected 1", cap_tx[25]); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (tx !== 1'b1) $display("FAIL mid_rst_tx: got %b expected 1", tx); else passed++;
    checks++; if (state !== ST_IDLE) $display("FAIL mid_rst_state: got %0d expected %0d", state, ST_IDLE); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mid_rst_done: got %b expected 0", done); else passed++;
    capture(FRAME + 4, -1, '0, -1, -1);
    low_cycles = 0;
    for (int c = 0; c < FRAME + 4; c++) if (cap_tx[c] !== 1'b1) low_cycles++;
    checks++; if (cap_done_n != 0) $display("FAIL mid_no_done: got %0d expected 0", cap_done_n); else passed++;
    checks++; if (low_cycles != 0) $display("FAIL mid_line_idle: got %0d low cycles expected 0", low_cycles); else passed++;
    send(10'h1C3, 1'b0);
    capture(FRAME + 2, -1, '0, -1, -1);
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(10'h1C3, c))
        $display("FAIL mid_new_tx[%0d]: got %b expected %b", c, cap_tx[c], exp_bit(10'h1C3, c));
      else passed++;
    end
    checks++; if (cap_done_at[0] != FRAME) $display("FAIL mid_new_done_at: got %0d expected %0d", cap_done_at[0], FRAME); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_busy_protect();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
